// File: rtl/shift_cipher_stream.sv
// Streaming shift cipher with modular wrap and a rolling multi-slot key.
// One symbol per IDLE -> CALC -> OUT pass; out-of-range symbols pass through flagged.
module shift_cipher_stream #(
    parameter int DATA_W    = 8,
    parameter int KEY_W     = 3,
    parameter int MOD       = 128,
    parameter int KEY_DEPTH = 4,
    localparam int PTR_W    = (KEY_DEPTH > 1) ? $clog2(KEY_DEPTH) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              select,
    input  logic [PTR_W:0]    key_len,
    input  logic              key_wr,
    input  logic [PTR_W-1:0]  key_addr,
    input  logic [KEY_W-1:0]  key_data,
    input  logic              key_restart,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

    localparam logic [PTR_W:0]  DEPTH_L = (PTR_W+1)'(KEY_DEPTH);
    localparam logic [DATA_W:0] MOD_X   = (DATA_W+1)'(MOD);

    state_t            state, state_next;
    logic [KEY_W-1:0]  keys [KEY_DEPTH];
    logic [PTR_W-1:0]  ptr, ptr_next, slot;
    logic [PTR_W:0]    eff_len, slot_inc;
    logic [DATA_W-1:0] data_r;
    logic              dec_r;
    logic [KEY_W-1:0]  k_r;
    logic              accept;
    logic [DATA_W:0]   wide_d, wide_k, sum, calc_res;
    logic              calc_err;

    assign accept = in_valid & in_ready;

    // Restart or a stale pointer beyond the new length both fall back to slot 0.
    always_comb begin
        eff_len  = (key_len == '0 || key_len > DEPTH_L) ? DEPTH_L : key_len;
        slot     = (key_restart || {1'b0, ptr} >= eff_len) ? '0 : ptr;
        slot_inc = {1'b0, slot} + 1'b1;
        ptr_next = (slot_inc == eff_len) ? '0 : slot_inc[PTR_W-1:0];
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_next = CALC;
            end
            CALC: state_next = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // k < MOD, so one conditional correction keeps the result in range.
    always_comb begin
        wide_d   = {1'b0, data_r};
        wide_k   = (DATA_W+1)'(k_r);
        sum      = wide_d + wide_k;
        calc_err = 1'b0;
        calc_res = wide_d;
        if (wide_d >= MOD_X) begin
            calc_err = 1'b1;
        end else if (!dec_r) begin
            calc_res = (sum >= MOD_X) ? sum - MOD_X : sum;
        end else begin
            calc_res = (wide_d >= wide_k) ? wide_d - wide_k : wide_d + MOD_X - wide_k;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            ptr      <= '0;
            data_r   <= '0;
            dec_r    <= 1'b0;
            k_r      <= '0;
            out_data <= '0;
            out_err  <= 1'b0;
            for (int unsigned i = 0; i < KEY_DEPTH; i++) keys[i] <= '0;
        end else begin
            state <= state_next;
            if (key_wr && ({1'b0, key_addr} < DEPTH_L)) keys[key_addr] <= key_data;
            if (accept) begin
                data_r <= in_data;
                dec_r  <= select;
                k_r    <= keys[slot];
                ptr    <= ptr_next;
            end else if (key_restart) begin
                ptr <= '0;
            end
            if (state == CALC) begin
                out_data <= DATA_W'(calc_res);
                out_err  <= calc_err;
            end
        end
    end

endmodule

// File: tb/tb_shift_cipher_stream.sv
// Scoreboard bench for shift_cipher_stream: driver pushes model results, monitor pops on output.
module tb_shift_cipher_stream;

    logic       CLK, RST;
    logic       in_valid, in_ready, select, key_wr, key_restart;
    logic       out_valid, out_ready, out_err, busy;
    logic [7:0] in_data, out_data;
    logic [2:0] key_len, key_data;
    logic [1:0] key_addr;

    shift_cipher_stream #(.DATA_W(8), .KEY_W(3), .MOD(128), .KEY_DEPTH(4)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .select(select), .key_len(key_len), .key_wr(key_wr),
        .key_addr(key_addr), .key_data(key_data), .key_restart(key_restart),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .busy(busy)
    );

    int tests = 0;
    int fails = 0;
    int ready_mode = 0;   // 0: ready high, 1: random, 2: driven by test
    int ref_keys [4];
    int ref_ptr = 0;
    logic [8:0] exp_q [$];

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] cipher(input int d, input bit dec, input int k);
        if (d >= 128) return {1'b1, 8'(d)};
        if (dec) return {1'b0, 8'((d - k + 128) % 128)};
        return {1'b0, 8'((d + k) % 128)};
    endfunction

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (ready_mode == 0) out_ready = 1'b1;
            else if (ready_mode == 1) out_ready = 1'($urandom % 2);
        end
    end

    // Monitor: every presented output must equal the queue head until it is taken.
    initial begin
        forever begin
            @(negedge CLK);
            if (out_valid) begin
                check("in_ready_low_in_out", int'(in_ready), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    check("out_data", int'(out_data), int'(exp_q[0][7:0]));
                    check("out_err", int'(out_err), int'(exp_q[0][8]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic send(input int d, input bit dec, input int len,
                        input bit wr, input int wa, input int wd, input bit rs);
        int budget = 0;
        int L, slot, k;
        @(negedge CLK);
        in_valid = 1'b1;
        in_data  = 8'(d);
        select   = dec;
        key_len  = 3'(len);
        while (!in_ready && budget < 200) begin
            @(negedge CLK);
            budget++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        key_wr      = wr;
        key_addr    = 2'(wa);
        key_data    = 3'(wd);
        key_restart = rs;
        L    = (len == 0 || len > 4) ? 4 : len;
        slot = (rs || ref_ptr >= L) ? 0 : ref_ptr;
        k    = ref_keys[slot];
        if (wr) ref_keys[wa] = wd;
        ref_ptr = (slot + 1 == L) ? 0 : slot + 1;
        exp_q.push_back(cipher(d, dec, k));
        @(negedge CLK);
        in_valid    = 1'b0;
        key_wr      = 1'b0;
        key_restart = 1'b0;
    endtask

    task automatic key_write(input int a, input int v);
        @(negedge CLK);
        key_wr = 1'b1; key_addr = 2'(a); key_data = 3'(v);
        ref_keys[a] = v;
        @(negedge CLK);
        key_wr = 1'b0;
    endtask

    task automatic restart_only();
        @(negedge CLK);
        key_restart = 1'b1;
        ref_ptr = 0;
        @(negedge CLK);
        key_restart = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int budget = 0;
        while (!out_valid && budget < 50) begin
            @(negedge CLK);
            budget++;
        end
        check(name, int'(out_valid), 1);
    endtask

    task automatic drain();
        int budget = 0;
        while (exp_q.size() != 0 && budget < 2000) begin
            @(negedge CLK);
            budget++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        RST = 1'b1; in_valid = 0; in_data = 0; select = 0; key_len = 0;
        key_wr = 0; key_addr = 0; key_data = 0; key_restart = 0; out_ready = 1;
        foreach (ref_keys[i]) ref_keys[i] = 0;
        #12;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_err", int'(out_err), 0);
        @(negedge CLK);
        RST = 1'b0;

        // Encrypt wrap with latency check
        key_write(0, 5);
        restart_only();
        send(125, 0, 1, 0, 0, 0, 0);
        check("lat_calc_valid", int'(out_valid), 0);
        check("lat_calc_busy", int'(busy), 1);
        @(negedge CLK);
        check("lat_out_valid", int'(out_valid), 1);
        drain();

        // Decrypt wrap and full round trip for every key
        send(2, 1, 1, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            key_write(0, k);
            for (int d = 0; d < 128; d++) begin
                send(d, 0, 1, 0, 0, 0, 0);
                send((d + k) % 128, 1, 1, 0, 0, 0, 0);
            end
        end
        drain();

        // Rolling key, length 3
        key_write(0, 1); key_write(1, 2); key_write(2, 3); key_write(3, 4);
        restart_only();
        for (int i = 0; i < 4; i++) send(10, 0, 3, 0, 0, 0, 0);
        drain();

        // Error passthrough under backpressure
        restart_only();
        @(posedge CLK); #1;
        ready_mode = 2; out_ready = 1'b0;
        send(200, 0, 4, 0, 0, 0, 0);
        wait_valid("err_valid_timeout");
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("stall_in_ready", int'(in_ready), 0);
            check("stall_valid", int'(out_valid), 1);
            check("stall_data", int'(out_data), 200);
            check("stall_err", int'(out_err), 1);
        end
        @(posedge CLK); #1;
        out_ready = 1'b1; ready_mode = 0;
        send(10, 0, 4, 0, 0, 0, 0);
        drain();

        // Collisions: write vs accept on same slot, restart with accept
        key_write(0, 1);
        restart_only();
        send(10, 0, 4, 1, 0, 7, 0);
        send(20, 0, 4, 0, 0, 0, 0);
        send(10, 0, 4, 0, 0, 0, 1);
        drain();

        // Reset while holding an output
        @(posedge CLK); #1;
        ready_mode = 2; out_ready = 1'b0;
        send(50, 0, 4, 0, 0, 0, 0);
        wait_valid("rst_mid_valid_timeout");
        #2;
        RST = 1'b1;
        #1;
        check("rst_async_valid", int'(out_valid), 0);
        exp_q.delete();
        foreach (ref_keys[i]) ref_keys[i] = 0;
        ref_ptr = 0;
        @(negedge CLK);
        RST = 1'b0;
        ready_mode = 0;
        @(negedge CLK);
        check("rst2_in_ready", int'(in_ready), 1);
        check("rst2_busy", int'(busy), 0);
        check("rst2_out_data", int'(out_data), 0);
        send(9, 0, 1, 0, 0, 0, 0);
        drain();

        // Randomized traffic with backpressure and key activity
        ready_mode = 1;
        for (int i = 0; i < 300; i++) begin
            case ($urandom % 10)
                0: key_write(int'($urandom % 4), int'($urandom % 8));
                1: restart_only();
                default: send(int'($urandom % 256), 1'($urandom % 2), int'($urandom % 8),
                              ($urandom % 4) == 0, int'($urandom % 4), int'($urandom % 8),
                              ($urandom % 8) == 0);
            endcase
        end
        drain();
        ready_mode = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
